// File: rtl/control_pipe.sv
// control_pipe: registered instruction decoder with load stall and branch flush; CONTROL_PIPE_ILLEGAL_TRAP_EN adds the illegal-branch trap output
module control_pipe #(
  parameter int OPWIDTH   = 6,
  parameter int MCODEBITS = 6,
  parameter int MEM_LAT   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  input  logic                 take_branch,
  output logic                 out_valid,
  output logic                 Branch,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 absj,
  output logic [1:0]           ALUSrc,
  output logic [1:0]           MemtoReg,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy
`ifdef CONTROL_PIPE_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);
  localparam int XW = (OPWIDTH > MCODEBITS) ? OPWIDTH : MCODEBITS;
  typedef enum logic {RUN, LOAD_WAIT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] cls, sub;
  logic go;
  logic [XW-1:0] ext;
  logic [OPWIDTH-1:0] op_field;
  logic d_br, d_mw, d_rw, d_aj, d_ill;
  logic [1:0] d_as, d_mr;
  logic [OPWIDTH-1:0] d_op;
  assign cls = instr[MCODEBITS-1 -: 3];
  assign sub = instr[2:0];
  assign instr_ready = (state == RUN);
  assign busy = (state == LOAD_WAIT);
  assign go = instr_valid & instr_ready & ~take_branch;
  assign ext = XW'(instr);
  assign op_field = ext[OPWIDTH-1:0];
  // decode the class field into control values
  always_comb begin
    d_br = 1'b0;
    d_mw = 1'b0;
    d_rw = 1'b0;
    d_aj = 1'b0;
    d_ill = 1'b0;
    d_as = 2'd0;
    d_mr = 2'd0;
    d_op = '1;
    case (cls)
      3'b000: begin d_rw = 1'b1; d_as = 2'd1; d_op = OPWIDTH'({instr[2], 2'b00}); end
      3'b001: begin d_rw = 1'b1; d_as = 2'd2; d_op = op_field; end
      3'b010: begin d_rw = 1'b1; d_as = 2'd1; d_mr = 2'd2; d_op = OPWIDTH'(4'b1111); end
      3'b011: begin
        d_br = 1'b1;
        d_as = 2'd2;
        d_op = op_field;
        d_aj = (sub == 3'b000) | (sub == 3'b001) | (sub == 3'b100);
`ifdef CONTROL_PIPE_ILLEGAL_TRAP_EN
        d_ill = (sub == 3'b111);
`endif
      end
      3'b100: begin d_rw = 1'b1; d_mr = 2'd2; end
      3'b101: begin d_rw = 1'b1; d_mr = 2'd1; end
      3'b110: d_mw = 1'b1;
      3'b111: begin d_rw = 1'b1; d_op = ~({OPWIDTH{1'b1}} >> 3); end
    endcase
  end
  // next state: enter LOAD_WAIT on a kept lb, leave when the counter hits 1
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == LOAD_WAIT) begin
      cnt_nxt = cnt - 4'd1;
      if (cnt == 4'd1) state_nxt = RUN;
    end else if (go && cls == 3'b101 && MEM_LAT > 0) begin
      state_nxt = LOAD_WAIT;
      cnt_nxt = 4'(MEM_LAT);
    end
  end
  // stall state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // decode/execute boundary register: decoded controls or a bubble
  always_ff @(posedge Clk) begin
    if (Reset || !go || d_ill) begin
      out_valid <= 1'b0;
      Branch <= 1'b0;
      MemWrite <= 1'b0;
      RegWrite <= 1'b0;
      absj <= 1'b0;
      ALUSrc <= 2'd0;
      MemtoReg <= 2'd0;
      ALUOp <= '0;
    end else begin
      out_valid <= 1'b1;
      Branch <= d_br;
      MemWrite <= d_mw;
      RegWrite <= d_rw;
      absj <= d_aj;
      ALUSrc <= d_as;
      MemtoReg <= d_mr;
      ALUOp <= d_op;
    end
  end
`ifdef CONTROL_PIPE_ILLEGAL_TRAP_EN
  // one-cycle trap pulse alongside the bubble of an illegal branch
  always_ff @(posedge Clk) begin
    illegal <= Reset ? 1'b0 : (go & d_ill);
  end
`endif
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed and random stimulus against a table-driven reference model of control_pipe
module tb_control_pipe;
  localparam int MEM_LAT = 2;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic instr_valid = 1'b0;
  logic [5:0] instr = '0;
  logic take_branch = 1'b0;
  logic instr_ready, out_valid, Branch, MemWrite, RegWrite, absj, busy;
  logic [1:0] ALUSrc, MemtoReg;
  logic [5:0] ALUOp;
  logic ill_obs;
  int checks = 0;
  int errors = 0;
  int br_t [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  int mw_t [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int rw_t [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
  int as_t [8] = '{1, 2, 1, 2, 0, 0, 0, 0};
  int mr_t [8] = '{0, 0, 2, 0, 2, 1, 0, 0};
  int e_ov, e_br, e_mw, e_rw, e_aj, e_as, e_mr, e_op, e_ill;
  int stall_left = 0;
  bit trap_en;

  control_pipe #(.OPWIDTH(6), .MCODEBITS(6), .MEM_LAT(MEM_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .take_branch(take_branch), .out_valid(out_valid),
    .Branch(Branch), .MemWrite(MemWrite), .RegWrite(RegWrite), .absj(absj),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .busy(busy)
`ifdef CONTROL_PIPE_ILLEGAL_TRAP_EN
    , .illegal(ill_obs)
`endif
  );
`ifndef CONTROL_PIPE_ILLEGAL_TRAP_EN
  assign ill_obs = 1'b0;
`endif

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic bubble();
    e_ov = 0; e_br = 0; e_mw = 0; e_rw = 0; e_aj = 0; e_as = 0; e_mr = 0; e_op = 0;
  endtask

  task automatic step(input bit r, input bit v, input logic [5:0] i, input bit tb);
    int c, s;
    bit acc;
    Reset = r; instr_valid = v; instr = i; take_branch = tb;
    acc = v && stall_left == 0;
    c = int'(i) / 8;
    s = int'(i) % 8;
    @(posedge Clk);
    e_ill = 0;
    if (r) begin
      bubble();
      stall_left = 0;
    end else begin
      if (stall_left > 0) stall_left--;
      if (acc && !tb && trap_en && c == 3 && s == 7) begin
        bubble();
        e_ill = 1;
      end else if (acc && !tb) begin
        e_ov = 1;
        e_br = br_t[c]; e_mw = mw_t[c]; e_rw = rw_t[c]; e_as = as_t[c]; e_mr = mr_t[c];
        e_op = (c == 0) ? ((s / 4) % 2) * 4 : (c == 1 || c == 3) ? int'(i) :
               (c == 2) ? 15 : (c == 7) ? 56 : 63;
        e_aj = (c == 3 && (s == 0 || s == 1 || s == 4)) ? 1 : 0;
        if (c == 5 && MEM_LAT > 0) stall_left = MEM_LAT;
      end else bubble();
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("Branch", 32'(Branch), 32'(e_br));
    chk("MemWrite", 32'(MemWrite), 32'(e_mw));
    chk("RegWrite", 32'(RegWrite), 32'(e_rw));
    chk("absj", 32'(absj), 32'(e_aj));
    chk("ALUSrc", 32'(ALUSrc), 32'(e_as));
    chk("MemtoReg", 32'(MemtoReg), 32'(e_mr));
    chk("ALUOp", 32'(ALUOp), 32'(e_op));
    chk("instr_ready", 32'(instr_ready), 32'(stall_left == 0));
    chk("busy", 32'(busy), 32'(stall_left > 0));
    chk("illegal", 32'(ill_obs), 32'(e_ill));
  endtask

  initial begin
`ifdef CONTROL_PIPE_ILLEGAL_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    step(1, 1, 6'b001101, 0);
    step(1, 1, 6'b001101, 0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    step(0, 1, 6'b001101, 0);
    chk("op_ALUOp", 32'(ALUOp), 32'b001101);
    chk("op_ALUSrc", 32'(ALUSrc), 32'd2);
    step(0, 1, 6'b000100, 0);
    chk("sh_ALUOp", 32'(ALUOp), 32'b000100);
    step(0, 1, 6'b010000, 0);
    chk("li_ALUOp", 32'(ALUOp), 32'b001111);
    step(0, 1, 6'b111000, 0);
    chk("par_ALUOp", 32'(ALUOp), 32'b111000);
    step(0, 1, 6'b101000, 0);
    chk("lb_MemtoReg", 32'(MemtoReg), 32'd1);
    chk("lb_ready_low", 32'(instr_ready), 32'd0);
    step(0, 1, 6'b110000, 0);
    step(0, 1, 6'b110000, 0);
    chk("stall_end_ready", 32'(instr_ready), 32'd1);
    step(0, 1, 6'b110000, 0);
    chk("sb_MemWrite", 32'(MemWrite), 32'd1);
    step(0, 1, 6'b011100, 0);
    chk("b_absj", 32'(absj), 32'd1);
    step(0, 1, 6'b011010, 0);
    chk("b_rel_absj", 32'(absj), 32'd0);
    step(0, 1, 6'b100000, 1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step(0, 1, 6'b101000, 1);
    chk("flushed_lb_ready", 32'(instr_ready), 32'd1);
    step(0, 1, 6'b101000, 0);
    step(1, 1, 6'b110000, 0);
    chk("reset_stall_busy", 32'(busy), 32'd0);
    step(0, 1, 6'b110000, 0);
    chk("post_reset_accept", 32'(MemWrite), 32'd1);
    step(0, 1, 6'b101000, 0);
    step(0, 1, 6'b010000, 1);
    step(0, 1, 6'b010000, 1);
    step(0, 1, 6'b010000, 0);
    step(0, 1, 6'b011111, 0);
    chk("b111_out_valid", 32'(out_valid), trap_en ? 32'd0 : 32'd1);
    step(0, 1, 6'b011111, 1);
    step(0, 0, 6'b011111, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           6'($urandom_range(0, 63)), $urandom_range(0, 4) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
